// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receive-side bus bundle between baud source, serial line, CPU bus and uart_rx_ctrl
//
// Signals:
//   BaudTick  one-Clock-wide oversample enable
//   RxD       synchronised serial input, idle high
//   RD        bus read strobe, consumes Dout
//   Dout      last accepted received word
//   RxRDY     Dout holds an unread word
//   ParityErr sticky parity error for the word in Dout
//   FrameErr  sticky framing error for the word in Dout
//   Overrun   a frame completed while RxRDY was set
//   Busy      receiver is inside a frame
// Modports: master = baud/line/bus side, slave = receiver.

interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 BaudTick;
    logic                 RxD;
    logic                 RD;
    logic [DATA_BITS-1:0] Dout;
    logic                 RxRDY;
    logic                 ParityErr;
    logic                 FrameErr;
    logic                 Overrun;
    logic                 Busy;

    modport master (
        output BaudTick, RxD, RD,
        input  Dout, RxRDY, ParityErr, FrameErr, Overrun, Busy
    );

    modport slave (
        input  BaudTick, RxD, RD,
        output Dout, RxRDY, ParityErr, FrameErr, Overrun, Busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampling UART receive controller with parity, stop-bit and overrun checking
//
// Ports:
//   Clock  system clock, rising edge
//   Reset  synchronous, active-high
//   bus    uart_rx_ctrl_if.slave: BaudTick/RxD/RD in; Dout/RxRDY/ParityErr/
//          FrameErr/Overrun/Busy out
// Parameters: DATA_BITS (5..9), OVERSAMPLE (even, >=4), PARITY_EN, PARITY_ODD,
//             STOP_BITS (1 or 2).

module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           Clock,
    input  logic           Reset,
    uart_rx_ctrl_if.slave  bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;   // this frame's parity mismatch
    logic                 ferr_q, ferr_d;   // this frame's stop-bit error
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 rxrdy_q, rxrdy_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q;
    logic                 complete;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            dout_q  <= '0;
            rxrdy_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            dout_q  <= dout_d;
            rxrdy_q <= rxrdy_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        dout_d   = dout_q;
        rxrdy_d  = rxrdy_q;
        pe_d     = pe_q;
        fe_d     = fe_q;
        ovr_d    = ovr_q;
        complete = 1'b0;

        if (bus.BaudTick) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.RxD) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        if (bus.RxD) begin
                            state_d = IDLE;
                        end else begin
                            // Valid start: per-frame error bits start clean here.
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {bus.RxD, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                            stop_d  = 1'b0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        perr_d  = bus.RxD ^ (^shift_q) ^ ODD;
                        tick_d  = '0;
                        stop_d  = 1'b0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        if (!bus.RxD) ferr_d = 1'b1;
                        tick_d = '0;
                        if (stop_q == STOP_LAST) begin
                            state_d  = IDLE;
                            complete = 1'b1;
                        end else begin
                            stop_d = stop_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A read on the completion cycle frees the holding register in time
        // for the new word, so it is accepted rather than counted as overrun.
        if (complete) begin
            if (!rxrdy_q || bus.RD) begin
                dout_d  = shift_d;
                rxrdy_d = 1'b1;
                pe_d    = perr_d;
                fe_d    = ferr_d;
                ovr_d   = bus.RD ? 1'b0 : ovr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.RD && rxrdy_q) begin
            rxrdy_d = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign bus.Dout      = dout_q;
    assign bus.RxRDY     = rxrdy_q;
    assign bus.ParityErr = pe_q;
    assign bus.FrameErr  = fe_q;
    assign bus.Overrun   = ovr_q;
    assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl (default and 7N2 configurations)

module tb_uart_rx_ctrl;
    logic Clock = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;

    uart_rx_ctrl_if #(.DATA_BITS(8)) ifa ();
    uart_rx_ctrl_if #(.DATA_BITS(7)) ifb ();

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut_a (.Clock(Clock), .Reset(rst_a), .bus(ifa));

    uart_rx_ctrl #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        dut_b (.Clock(Clock), .Reset(rst_b), .bus(ifb));

    // One BaudTick cycle followed by one idle cycle; outputs are stable at #1 after the edge.
    task automatic pulse(input int sel, input logic rxd, input logic rd);
        if (sel == 0) begin ifa.BaudTick = 1'b1; ifa.RxD = rxd; ifa.RD = rd; end
        else          begin ifb.BaudTick = 1'b1; ifb.RxD = rxd; ifb.RD = rd; end
        @(posedge Clock); #1;
        ifa.BaudTick = 1'b0; ifa.RD = 1'b0;
        ifb.BaudTick = 1'b0; ifb.RD = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic ticks(input int sel, input logic rxd, input int n);
        for (int k = 0; k < n; k++) pulse(sel, rxd, 1'b0);
    endtask

    task automatic read_strobe(input int sel);
        if (sel == 0) ifa.RD = 1'b1; else ifb.RD = 1'b1;
        @(posedge Clock); #1;
        ifa.RD = 1'b0; ifb.RD = 1'b0;
    endtask

    // Everything up to (not including) the mid-bit tick of the last stop bit.
    task automatic send_head(input int sel, input logic [8:0] data, input int nbits,
                             input bit par_en, input logic par, input int nstop,
                             input logic stop1, input logic last_stop);
        ticks(sel, 1'b1, 4);
        ticks(sel, 1'b0, 16);
        for (int i = 0; i < nbits; i++) ticks(sel, data[i], 16);
        if (par_en) ticks(sel, par, 16);
        if (nstop == 2) ticks(sel, stop1, 16);
        ticks(sel, last_stop, 8);
    endtask

    // Complete a frame: mid-stop tick (optionally with RD), then line back to idle.
    task automatic finish_frame(input int sel, input logic last_stop, input logic rd);
        pulse(sel, last_stop, rd);
    endtask

    task automatic test_reset;
        checks++; if (ifa.Dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", ifa.Dout); end
        checks++; if (ifa.RxRDY !== 1'b0) begin errors++; $display("FAIL reset_rxrdy got %b want 0", ifa.RxRDY); end
        checks++; if ({ifa.ParityErr, ifa.FrameErr, ifa.Overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ifa.ParityErr, ifa.FrameErr, ifa.Overrun}); end
        checks++; if (ifa.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifa.Busy); end
        checks++; if ({ifb.RxRDY, ifb.Busy, ifb.Dout} !== 9'h000) begin errors++; $display("FAIL reset_b got %h want 000", {ifb.RxRDY, ifb.Busy, ifb.Dout}); end
    endtask

    task automatic test_basic_a5;
        send_head(0, 9'h0A5, 8, 1, 1'b0, 1, 1'b1, 1'b1);
        checks++; if (ifa.Busy !== 1'b1) begin errors++; $display("FAIL a5_busy_mid got %b want 1", ifa.Busy); end
        checks++; if (ifa.RxRDY !== 1'b0) begin errors++; $display("FAIL a5_rxrdy_early got %b want 0", ifa.RxRDY); end
        finish_frame(0, 1'b1, 1'b0);
        checks++; if (ifa.Dout !== 8'hA5) begin errors++; $display("FAIL a5_dout got %h want a5", ifa.Dout); end
        checks++; if (ifa.RxRDY !== 1'b1) begin errors++; $display("FAIL a5_rxrdy got %b want 1", ifa.RxRDY); end
        checks++; if ({ifa.ParityErr, ifa.FrameErr, ifa.Overrun} !== 3'b000) begin errors++; $display("FAIL a5_flags got %b want 000", {ifa.ParityErr, ifa.FrameErr, ifa.Overrun}); end
        checks++; if (ifa.Busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end got %b want 0", ifa.Busy); end
        ticks(0, 1'b1, 8);
        read_strobe(0);
        checks++; if (ifa.RxRDY !== 1'b0) begin errors++; $display("FAIL a5_rd_clear got %b want 0", ifa.RxRDY); end
        checks++; if (ifa.Dout !== 8'hA5) begin errors++; $display("FAIL a5_dout_hold got %h want a5", ifa.Dout); end
        read_strobe(0);
        checks++; if ({ifa.RxRDY, ifa.Overrun} !== 2'b00) begin errors++; $display("FAIL a5_rd_idle got %b want 00", {ifa.RxRDY, ifa.Overrun}); end
    endtask

    task automatic test_false_start;
        ticks(0, 1'b1, 4);
        ticks(0, 1'b0, 1);
        checks++; if (ifa.Busy !== 1'b1) begin errors++; $display("FAIL fs_busy got %b want 1", ifa.Busy); end
        ticks(0, 1'b0, 3);
        ticks(0, 1'b1, 12);
        checks++; if (ifa.Busy !== 1'b0) begin errors++; $display("FAIL fs_idle got %b want 0", ifa.Busy); end
        checks++; if (ifa.RxRDY !== 1'b0) begin errors++; $display("FAIL fs_rxrdy got %b want 0", ifa.RxRDY); end
    endtask

    task automatic test_errors;
        send_head(0, 9'h03C, 8, 1, 1'b1, 1, 1'b1, 1'b1);
        finish_frame(0, 1'b1, 1'b0);
        checks++; if (ifa.Dout !== 8'h3C) begin errors++; $display("FAIL pe_dout got %h want 3c", ifa.Dout); end
        checks++; if ({ifa.ParityErr, ifa.FrameErr} !== 2'b10) begin errors++; $display("FAIL pe_flags got %b want 10", {ifa.ParityErr, ifa.FrameErr}); end
        ticks(0, 1'b1, 8);
        read_strobe(0);
        checks++; if (ifa.ParityErr !== 1'b0) begin errors++; $display("FAIL pe_rd_clear got %b want 0", ifa.ParityErr); end
        send_head(0, 9'h001, 8, 1, 1'b1, 1, 1'b1, 1'b0);
        finish_frame(0, 1'b0, 1'b0);
        checks++; if (ifa.Dout !== 8'h01) begin errors++; $display("FAIL fe_dout got %h want 01", ifa.Dout); end
        checks++; if ({ifa.ParityErr, ifa.FrameErr, ifa.RxRDY} !== 3'b011) begin errors++; $display("FAIL fe_flags got %b want 011", {ifa.ParityErr, ifa.FrameErr, ifa.RxRDY}); end
        ticks(0, 1'b1, 8);
        read_strobe(0);
        checks++; if ({ifa.FrameErr, ifa.RxRDY} !== 2'b00) begin errors++; $display("FAIL fe_rd_clear got %b want 00", {ifa.FrameErr, ifa.RxRDY}); end
    endtask

    task automatic test_overrun;
        send_head(0, 9'h011, 8, 1, 1'b0, 1, 1'b1, 1'b1);
        finish_frame(0, 1'b1, 1'b0);
        ticks(0, 1'b1, 8);
        send_head(0, 9'h022, 8, 1, 1'b0, 1, 1'b1, 1'b1);
        finish_frame(0, 1'b1, 1'b0);
        checks++; if (ifa.Dout !== 8'h11) begin errors++; $display("FAIL ov_dout got %h want 11", ifa.Dout); end
        checks++; if ({ifa.RxRDY, ifa.Overrun} !== 2'b11) begin errors++; $display("FAIL ov_flags got %b want 11", {ifa.RxRDY, ifa.Overrun}); end
        ticks(0, 1'b1, 8);
        read_strobe(0);
        checks++; if ({ifa.RxRDY, ifa.ParityErr, ifa.FrameErr, ifa.Overrun} !== 4'b0000) begin errors++; $display("FAIL ov_rd_clear got %b want 0000", {ifa.RxRDY, ifa.ParityErr, ifa.FrameErr, ifa.Overrun}); end
        send_head(0, 9'h033, 8, 1, 1'b0, 1, 1'b1, 1'b1);
        finish_frame(0, 1'b1, 1'b0);
        checks++; if (ifa.Dout !== 8'h33) begin errors++; $display("FAIL ov_third got %h want 33", ifa.Dout); end
        ticks(0, 1'b1, 8);
    endtask

    // 0x33 from the previous scenario is still unread; RD lands on 0x55's completion tick.
    task automatic test_back_to_back;
        send_head(0, 9'h055, 8, 1, 1'b0, 1, 1'b1, 1'b1);
        finish_frame(0, 1'b1, 1'b1);
        checks++; if (ifa.Dout !== 8'h55) begin errors++; $display("FAIL rdc_dout got %h want 55", ifa.Dout); end
        checks++; if ({ifa.RxRDY, ifa.Overrun} !== 2'b10) begin errors++; $display("FAIL rdc_flags got %b want 10", {ifa.RxRDY, ifa.Overrun}); end
        ticks(0, 1'b1, 8);
    endtask

    task automatic test_7n2_and_reset;
        send_head(1, 9'h05A, 7, 0, 1'b0, 2, 1'b1, 1'b0);
        checks++; if (ifb.RxRDY !== 1'b0) begin errors++; $display("FAIL b_early got %b want 0", ifb.RxRDY); end
        finish_frame(1, 1'b0, 1'b0);
        checks++; if (ifb.Dout !== 7'h5A) begin errors++; $display("FAIL b_dout got %h want 5a", ifb.Dout); end
        checks++; if ({ifb.RxRDY, ifb.FrameErr, ifb.ParityErr} !== 3'b110) begin errors++; $display("FAIL b_flags got %b want 110", {ifb.RxRDY, ifb.FrameErr, ifb.ParityErr}); end
        ticks(1, 1'b1, 8);
        ticks(1, 1'b0, 16);
        ticks(1, 1'b1, 40);
        checks++; if (ifb.Busy !== 1'b1) begin errors++; $display("FAIL b_busy_mid got %b want 1", ifb.Busy); end
        rst_b = 1'b1;
        @(posedge Clock); #1;
        rst_b = 1'b0;
        checks++; if ({ifb.Dout, ifb.RxRDY, ifb.ParityErr, ifb.FrameErr, ifb.Overrun, ifb.Busy} !== 12'h000) begin errors++; $display("FAIL b_reset got %h want 000", {ifb.Dout, ifb.RxRDY, ifb.ParityErr, ifb.FrameErr, ifb.Overrun, ifb.Busy}); end
        ticks(1, 1'b1, 20);
        checks++; if ({ifb.RxRDY, ifb.Busy} !== 2'b00) begin errors++; $display("FAIL b_after_reset got %b want 00", {ifb.RxRDY, ifb.Busy}); end
    endtask

    initial begin
        ifa.BaudTick = 1'b0; ifa.RxD = 1'b1; ifa.RD = 1'b0;
        ifb.BaudTick = 1'b0; ifb.RxD = 1'b1; ifb.RD = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        test_reset;
        test_basic_a5;
        test_false_start;
        test_errors;
        test_overrun;
        test_back_to_back;
        test_7n2_and_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Parametrised UART receive controller, next generation of the fixed 8-bit receiver FSM.
- Oversamples a pre-synchronised serial line and validates the start bit at mid-bit.
- Shifts in a configurable number of data bits LSB-first, then checks optional parity and 1 or 2 stop bits.
- Presents the received word to the CPU bus with a ready flag, sticky error flags and overrun detection; sits between the baud-tick generator and the bus interface.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, BaudTick pulses per bit period (even, >=4)
PARITY_EN, 1, 1 = parity bit present after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits checked (1 or 2)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
BaudTick  in  1  one-Clock-wide oversample enable
RxD  in  1  serial input, already synchronised; idle high
RD  in  1  bus read strobe, one Clock wide; consumes Dout
Dout  out  DATA_BITS  last accepted received word
RxRDY  out  1  Dout holds an unread word
ParityErr  out  1  sticky parity error for the word in Dout
FrameErr  out  1  sticky framing error (a stop bit sampled 0)
Overrun  out  1  sticky: a frame completed while RxRDY=1
Busy  out  1  1 whenever FSM is not in IDLE

Behaviour:
- Reset: state IDLE; tick, bit and stop counters = 0; shift register = 0; Dout=0; RxRDY=0; ParityErr=0; FrameErr=0; Overrun=0; Busy=0. Reset mid-frame aborts the frame with no flag updates.
- All state and counter advances occur only on cycles with BaudTick=1, except RD handling and output loads, which act on any Clock.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on BaudTick with RxD=0, go to START and clear the tick counter.
- START: count ticks. At tick OVERSAMPLE/2-1 (mid start bit), sample RxD.
  - RxD=1: false start, return to IDLE.
  - RxD=0: go to DATA and clear the tick and bit counters.
- DATA: at tick OVERSAMPLE-1, sample RxD into the shift register MSB and shift right, so the first received bit ends in bit 0.
  - After bit index DATA_BITS-1, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: at tick OVERSAMPLE-1, compare RxD with the expected parity.
  - Expected = XOR of data bits, inverted when PARITY_ODD=1.
  - Latch the mismatch result internally, then go to STOP.
- STOP: at tick OVERSAMPLE-1, sample RxD; a 0 sets the internal frame-error bit. Repeat STOP_BITS times.
- Frame completion occurs on the last stop sample, at mid-bit. That same cycle the FSM returns to IDLE, so a start bit immediately following is detected.
- Completion with RxRDY=0 (or RD=1 in the same cycle):
  - Dout <= shift register; RxRDY <= 1.
  - ParityErr and FrameErr are loaded from this frame's internal bits; they are not ORed with old values.
- Completion with RxRDY=1 and RD=0: Dout, ParityErr and FrameErr are unchanged, Overrun <= 1, and the frame is dropped.
- RD=1 with no completion that cycle: next edge RxRDY <= 0, ParityErr <= 0, FrameErr <= 0, Overrun <= 0. Dout holds its value.
- RD while RxRDY=0: no effect.
- Busy is registered and equals (state != IDLE).
- A BaudTick that coincides with completion is consumed by the STOP sample; IDLE evaluates starting with the next tick.
- Counter widths: tick counter ceil(log2(OVERSAMPLE)) bits, bit counter ceil(log2(DATA_BITS)) bits; no wrap occurs beyond the stated terminal values.

Test Plan:
- Default params, send 0xA5 with even parity bit 0 and stop 1 -> Dout=0xA5, RxRDY=1, ParityErr=0, FrameErr=0 at the mid-stop tick; RD -> RxRDY=0 next cycle.
- RxD low for 4 ticks then high (OVERSAMPLE=16) -> false start, FSM back to IDLE, RxRDY stays 0, Busy pulses then returns to 0.
- Send 0x3C with parity bit 1 (wrong for even) -> Dout=0x3C, ParityErr=1; then stop bit 0 on a new frame 0x01 after RD -> FrameErr=1, ParityErr=0.
- Two frames 0x11 then 0x22 with no RD -> Dout=0x11, Overrun=1; RD -> all flags 0; third frame 0x33 -> Dout=0x33.
- RD asserted on the exact completion cycle of frame 0x55 while RxRDY=1 -> Dout=0x55, RxRDY=1, Overrun=0.
- DATA_BITS=7, PARITY_EN=0, STOP_BITS=2, second stop bit 0 -> FrameErr=1 with Dout=7-bit value; then Reset pulse mid-data on the next frame -> all outputs 0, FSM in IDLE.
